router_pkt_buffer: RTL

Clocked multi-port packet buffer for the custom router. It holds up to DEPTH packets of at most WIDTH bytes each. A single input stream writes packets, and NPORTS output ports each stream out, in arrival order, the packets whose destination mask selects them. An entry is freed only after every port has either read it or skipped it, so multicast packets are stored once.

---
 rtl/router_pkg.sv | 27 ++
 rtl/router_pkt_buffer_if.sv | 32 +++
 rtl/router_buf_rd_port.sv | 89 ++++++++
 rtl/router_pkt_buffer.sv | 135 +++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared defaults, port FSM state and entry metadata for router_pkt_buffer
// Contents:
//   *_DEF        default parameter values used by the buffer and its read ports
//   port_state_e per-port FSM state (SCAN looks for the next entry, READ streams it)
//   entry_meta_t per-entry bookkeeping; field widths follow the default geometry
package router_pkg;

  localparam int DEPTH_DEF  = 4;
  localparam int WIDTH_DEF  = 16;
  localparam int UWIDTH_DEF = 8;
  localparam int NPORTS_DEF = 3;
  localparam int LEN_SZ_DEF = $clog2(WIDTH_DEF + 1);

  typedef enum logic {
    SCAN = 1'b0,
    READ = 1'b1
  } port_state_e;

  // pending[p] stays set until port p has read or skipped the entry.
  typedef struct packed {
    logic                  valid;
    logic [LEN_SZ_DEF-1:0] len;
    logic [NPORTS_DEF-1:0] dest;
    logic [NPORTS_DEF-1:0] pending;
  } entry_meta_t;

endpackage

// File: rtl/router_pkt_buffer_if.sv
// rtl/router_pkt_buffer_if.sv - write stream and per-port read streams of router_pkt_buffer
// Signals:
//   wr_valid/wr_ready/wr_data/wr_last/wr_dest  single input packet stream
//   rd_valid/rd_ready/rd_data/rd_last          NPORTS output streams, port p at bit p
//                                              (rd_data slice [p*UWIDTH +: UWIDTH])
// Modports: master = producer/consumers, slave = buffer.
interface router_pkt_buffer_if #(
  parameter int UWIDTH = 8,
  parameter int NPORTS = 3
);

  logic                     wr_valid;
  logic                     wr_ready;
  logic [UWIDTH-1:0]        wr_data;
  logic                     wr_last;
  logic [NPORTS-1:0]        wr_dest;
  logic [NPORTS-1:0]        rd_valid;
  logic [NPORTS-1:0]        rd_ready;
  logic [NPORTS*UWIDTH-1:0] rd_data;
  logic [NPORTS-1:0]        rd_last;

  modport master (
    output wr_valid, wr_data, wr_last, wr_dest, rd_ready,
    input  wr_ready, rd_valid, rd_data, rd_last
  );

  modport slave (
    input  wr_valid, wr_data, wr_last, wr_dest, rd_ready,
    output wr_ready, rd_valid, rd_data, rd_last
  );

endinterface

// File: rtl/router_buf_rd_port.sv
// rtl/router_buf_rd_port.sv - one output port walker: scans entries in order, skips or streams them
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   ent_valid/pending/dest/len  metadata of the entry at ptr, as seen by this port
//   rd_ready             consumer ready
//   rd_valid, rd_last    stream outputs for this port
//   clr_pending          pulse: this port is done with entry ptr
//   ptr, ridx            entry index and byte index currently addressed
module router_buf_rd_port
  import router_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int PTR_SZ = $clog2(DEPTH),
  parameter int LEN_SZ = $clog2(WIDTH + 1),
  parameter int IDX_SZ = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ent_valid,
  input  logic              ent_pending,
  input  logic              ent_dest,
  input  logic [LEN_SZ-1:0] ent_len,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic              rd_last,
  output logic              clr_pending,
  output logic [PTR_SZ-1:0] ptr,
  output logic [IDX_SZ-1:0] ridx
);

  port_state_e       state, state_nxt;
  logic [PTR_SZ-1:0] ptr_nxt, ptr_inc;
  logic [IDX_SZ-1:0] ridx_nxt;
  logic              last_byte;

  assign ptr_inc   = (ptr == PTR_SZ'(DEPTH - 1)) ? '0 : ptr + PTR_SZ'(1);
  assign last_byte = (LEN_SZ'(ridx) == ent_len - LEN_SZ'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SCAN;
      ptr   <= '0;
      ridx  <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      ridx  <= ridx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    ridx_nxt    = ridx;
    rd_valid    = 1'b0;
    rd_last     = 1'b0;
    clr_pending = 1'b0;
    case (state)
      SCAN: begin
        // The entry being filled is never valid, so scanning cannot overtake the writer.
        if (ent_valid && ent_pending) begin
          if (ent_dest) begin
            state_nxt = READ;
          end else begin
            clr_pending = 1'b1;
            ptr_nxt     = ptr_inc;
          end
        end
      end
      READ: begin
        rd_valid = 1'b1;
        rd_last  = last_byte;
        if (rd_ready) begin
          if (last_byte) begin
            clr_pending = 1'b1;
            ptr_nxt     = ptr_inc;
            ridx_nxt    = '0;
            state_nxt   = SCAN;
          end else begin
            ridx_nxt = ridx + IDX_SZ'(1);
          end
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

endmodule

// File: rtl/router_pkt_buffer.sv
// rtl/router_pkt_buffer.sv - shared packet store with in-order multicast delivery to NPORTS ports
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         router_pkt_buffer_if.slave: write stream in, NPORTS read streams out
//   count       committed, not yet freed entries
//   full, empty count==DEPTH / count==0
//   trunc_err   sticky: a packet was cut at WIDTH bytes
module router_pkt_buffer
  import router_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WIDTH  = WIDTH_DEF,
  parameter int UWIDTH = UWIDTH_DEF,
  parameter int NPORTS = NPORTS_DEF,
  parameter int PTR_SZ = $clog2(DEPTH),
  parameter int LEN_SZ = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  router_pkt_buffer_if.slave bus,
  output logic [PTR_SZ:0]    count,
  output logic               full,
  output logic               empty,
  output logic               trunc_err
);

  localparam int              IDX_SZ  = $clog2(WIDTH);
  localparam logic [PTR_SZ:0] CNT_MAX = (PTR_SZ + 1)'(DEPTH);

  logic [UWIDTH-1:0] mem [DEPTH][WIDTH];
  entry_meta_t       meta [DEPTH];
  logic [PTR_SZ-1:0] head, tail;
  logic [IDX_SZ-1:0] widx;
  logic [NPORTS-1:0] wdest;
  logic              dropping;

  logic              accept, store, commit, free;
  logic [NPORTS-1:0] commit_dest;
  logic [PTR_SZ-1:0] port_ptr  [NPORTS];
  logic [IDX_SZ-1:0] port_ridx [NPORTS];
  logic [NPORTS-1:0] clr_pend;
  logic [NPORTS-1:0] port_valid;

  function automatic logic [PTR_SZ-1:0] wrap_inc(input logic [PTR_SZ-1:0] p);
    return (p == PTR_SZ'(DEPTH - 1)) ? '0 : p + PTR_SZ'(1);
  endfunction

  // While discarding the tail of a truncated packet the input keeps flowing even if full.
  assign bus.wr_ready = dropping || (count < CNT_MAX);
  assign accept       = bus.wr_valid && bus.wr_ready;
  assign store        = accept && !dropping;
  assign commit       = store && (bus.wr_last || (widx == IDX_SZ'(WIDTH - 1)));
  assign commit_dest  = (widx == '0) ? bus.wr_dest : wdest;
  assign free         = meta[head].valid && (meta[head].pending == '0);
  assign full         = (count == CNT_MAX);
  assign empty        = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) meta[i] <= '0;
      head      <= '0;
      tail      <= '0;
      widx      <= '0;
      wdest     <= '0;
      dropping  <= 1'b0;
      count     <= '0;
      trunc_err <= 1'b0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (clr_pend[p]) meta[port_ptr[p]].pending[p] <= 1'b0;
      end
      if (free) begin
        meta[head].valid <= 1'b0;
        head             <= wrap_inc(head);
      end
      // head==tail only when empty (no free) or full (no commit), so these never collide.
      if (store) begin
        if (widx == '0) wdest <= bus.wr_dest;
        if (commit) begin
          meta[tail] <= '{valid:   1'b1,
                          len:     LEN_SZ'(widx) + LEN_SZ'(1),
                          dest:    commit_dest,
                          pending: {NPORTS{1'b1}}};
          tail <= wrap_inc(tail);
          widx <= '0;
          if (!bus.wr_last) begin
            trunc_err <= 1'b1;
            dropping  <= 1'b1;
          end
        end else begin
          widx <= widx + IDX_SZ'(1);
        end
      end else if (accept && bus.wr_last) begin
        dropping <= 1'b0;
      end
      if (commit && !free) begin
        count <= count + (PTR_SZ + 1)'(1);
      end else if (!commit && free) begin
        count <= count - (PTR_SZ + 1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (store) mem[tail][widx] <= bus.wr_data;
  end

  for (genvar p = 0; p < NPORTS; p++) begin : g_port
    router_buf_rd_port #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH),
      .PTR_SZ(PTR_SZ),
      .LEN_SZ(LEN_SZ),
      .IDX_SZ(IDX_SZ)
    ) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .ent_valid  (meta[port_ptr[p]].valid),
      .ent_pending(meta[port_ptr[p]].pending[p]),
      .ent_dest   (meta[port_ptr[p]].dest[p]),
      .ent_len    (meta[port_ptr[p]].len),
      .rd_ready   (bus.rd_ready[p]),
      .rd_valid   (port_valid[p]),
      .rd_last    (bus.rd_last[p]),
      .clr_pending(clr_pend[p]),
      .ptr        (port_ptr[p]),
      .ridx       (port_ridx[p])
    );

    assign bus.rd_valid[p] = port_valid[p];
    assign bus.rd_data[p*UWIDTH +: UWIDTH] =
      port_valid[p] ? mem[port_ptr[p]][port_ridx[p]] : '0;
  end

endmodule
